// File: rtl/train_if.sv
// train_if: handshake and datapath signals between the host and train_controller.
interface train_if #(
  parameter int ADDR_W  = 8,
  parameter int EPOCH_W = 5
);
  logic               start;
  logic               sample_err;
  logic               init_w;
  logic               rd_en;
  logic [ADDR_W-1:0]  addr;
  logic               upd_w;
  logic               busy;
  logic               done;
  logic               converged;
  logic [EPOCH_W-1:0] epoch;
  logic [ADDR_W-1:0]  err_cnt;
  modport master (
    output start, sample_err,
    input  init_w, rd_en, addr, upd_w, busy, done, converged, epoch, err_cnt
  );
  modport slave (
    input  start, sample_err,
    output init_w, rd_en, addr, upd_w, busy, done, converged, epoch, err_cnt
  );
endinterface

// File: rtl/train_controller.sv
// train_controller: epoch/sample sequencer for the training pass; all outputs decoded from registers.
module train_controller #(
  parameter int N_SAMPLES = 150,
  parameter int MAX_EPOCH = 16,
  parameter int ADDR_W    = 8,
  parameter int EPOCH_W   = 5
) (
  input  logic    clk,
  input  logic    rst,
  train_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, INIT, FETCH, EVAL, UPDATE, CHECK, DONE} state_t;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCH - 1);
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, err_q, err_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               conv_q, conv_d;
  logic               last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      epoch_q <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      epoch_q <= epoch_d;
      conv_q  <= conv_d;
    end
  end
  assign last = addr_q == LAST_ADDR;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    epoch_d = epoch_q;
    conv_d  = conv_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = INIT;
        addr_d  = '0;
        err_d   = '0;
        epoch_d = '0;
        conv_d  = 1'b0;
      end
      INIT:  state_d = FETCH;
      FETCH: state_d = EVAL;
      EVAL: if (bus.sample_err) begin
        err_d   = err_q + 1'b1;
        state_d = UPDATE;
      end else begin
        state_d = last ? CHECK : FETCH;
        addr_d  = last ? addr_q : addr_q + 1'b1;
      end
      UPDATE: begin
        state_d = last ? CHECK : FETCH;
        addr_d  = last ? addr_q : addr_q + 1'b1;
      end
      CHECK: if (err_q == '0) begin
        conv_d  = 1'b1;
        state_d = DONE;
      end else if (epoch_q == LAST_EPOCH) begin
        state_d = DONE;
      end else begin
        epoch_d = epoch_q + 1'b1;
        addr_d  = '0;
        err_d   = '0;
        state_d = FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.init_w    = state_q == INIT;
  assign bus.rd_en     = state_q == FETCH;
  assign bus.upd_w     = state_q == UPDATE;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.converged = conv_q;
  assign bus.addr      = addr_q;
  assign bus.epoch     = epoch_q;
  assign bus.err_cnt   = err_q;
endmodule
